dfii_init_sequencer: RTL and testbench
======================================

DFII_INIT_SEQUENCER -- requirements
Module: dfii_init_sequencer

Interface
REQ-001 Parameter CSR_BASE, default 30'h2400, word address of DFII CONTROL register (COMMAND=+1, ISSUE=+2, ADDR=+3, BADDR=+4).
REQ-002 Parameter RESET_WAIT, default 35, clk cycles between start and first bus write.
REQ-003 Parameter DLLK_CYCLES, default 600, idle cycles after second MR0 issue (tDLLK).
REQ-004 Parameter ZQINIT_CYCLES, default 600, idle cycles after ZQCL issue (tZQinit).
REQ-005 Parameter ACK_TIMEOUT, default 255, max cycles a bus write may wait for ack.
REQ-006 Ports: one clock; reset is synchronous and active-high.
REQ-007 clk  in  1  sole clock; all state changes on rising edge.
REQ-008 rst  in  1  synchronous active-high reset.
REQ-009 start  in  1  single-cycle request to run init sequence.
REQ-010 busy  out  1  high from cycle after accepted start until DONE/ERROR.
REQ-011 done  out  1  high in DONE state (sticky until rst or new start).
REQ-012 error  out  1  high in ERROR state (sticky until rst).
REQ-013 step  out  5  index of current sequence entry (0..28).
REQ-014 wb_adr  out  30; wb_dat_w  out  32; wb_sel  out  4; wb_cyc, wb_stb, wb_we  out  1; wb_ack  in  1; Wishbone classic master toward controller CSR/DFII port.

Function
REQ-015 States: IDLE, RST_WAIT, WRITE, GAP, DELAY, DONE, ERROR.
REQ-016 IDLE/DONE + start=1 -> RST_WAIT, step=0, counter loaded RESET_WAIT, done cleared; start ignored in all other states.
REQ-017 Fixed 29-write table (register, data): ADDR 0; BADDR 0; CONTROL 0x0C; CONTROL 0x0E; MR2: ADDR 0x200, BADDR 2, COMMAND 0x0F, ISSUE 1; MR3: ADDR 0, BADDR 3, COMMAND 0x0F, ISSUE 1; MR1: ADDR 0x6, BADDR 1, COMMAND 0x0F, ISSUE 1; MR0 DLL reset: ADDR 0x320, BADDR 0, COMMAND 0x0F, ISSUE 1; MR0: ADDR 0x220, BADDR 0, COMMAND 0x0F, ISSUE 1; ZQCL: ADDR 0x400, BADDR 0, COMMAND 0x03, ISSUE 1; CONTROL 0x01.
REQ-018 DELAY of DLLK_CYCLES inserted after step 23 ack; DELAY of ZQINIT_CYCLES after step 27 ack.
REQ-019 WRITE: wb_cyc=wb_stb=wb_we=1, wb_sel=4'hF, wb_adr=CSR_BASE+offset, wb_dat_w=data zero-extended to 32 bits; all held stable until ack.
REQ-020 On edge where wb_ack=1 in WRITE: cyc/stb deasserted next cycle; go to GAP (one idle cycle), or DELAY per REQ-018, or DONE after step 28.
REQ-021 GAP lasts exactly 1 cycle, then WRITE with step+1; no back-to-back bus cycles.
REQ-022 wb_ack outside WRITE ignored.
REQ-023 Timeout counter cleared on WRITE entry, increments each WRITE cycle without ack; reaching ACK_TIMEOUT -> ERROR, cyc/stb dropped same edge, step frozen.
REQ-024 Delay counters count down to 0 inclusive of load cycle; DELAY exit exactly N cycles after entry.
REQ-025 ERROR exits only on rst.

Reset
REQ-026 rst=1: state IDLE, step=0, busy=done=error=0, wb_cyc=wb_stb=wb_we=0, wb_adr=0, wb_dat_w=0, wb_sel=0, counters 0.
REQ-027 rst mid-transaction drops wb_cyc/wb_stb at that edge; no sequence resumption; next start restarts at step 0.

Verification
REQ-028 Start with 1-cycle-ack responder -> 29 writes in REQ-017 order, word addresses 0x2400..0x2404, done=1, busy=0 after final CONTROL=0x01.
REQ-029 Measure idle cycles between step 23 ack and step 24 stb -> exactly DLLK_CYCLES; step 27 to 28 -> ZQINIT_CYCLES.
REQ-030 Responder withholds ack on step 5 (BADDR=2) -> error=1 after ACK_TIMEOUT cycles, wb_cyc=0, step=5, later start ignored.
REQ-031 Responder with random 0-10 cycle ack delay -> identical write sequence; adr/dat stable while stb high without ack.
REQ-032 rst asserted during step 12 WRITE -> outputs at reset values next cycle; new start replays from step 0.
REQ-033 start pulsed while busy -> no effect; start pulsed in DONE -> full sequence reruns, done cleared.

Source files
------------

// File: rtl/dfii_init_sequencer.sv
// dfii_init_sequencer: replays the DDR3 mode-register/ZQ init table onto the DFII CSRs over Wishbone.
module dfii_init_sequencer #(
  parameter logic [29:0] CSR_BASE      = 30'h2400,
  parameter int          RESET_WAIT    = 35,
  parameter int          DLLK_CYCLES   = 600,
  parameter int          ZQINIT_CYCLES = 600,
  parameter int          ACK_TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [4:0]  step,
  output logic [29:0] wb_adr,
  output logic [31:0] wb_dat_w,
  output logic [3:0]  wb_sel,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  input  logic        wb_ack
);
  typedef enum logic [2:0] {IDLE, RST_WAIT, WRITE, GAP, DELAY, DONE, ERROR} state_t;
  localparam logic [2:0] CTL = 3'd0, CMD = 3'd1, ISS = 3'd2, ADR = 3'd3, BAD = 3'd4;
  localparam logic [15:0] RW = 16'(RESET_WAIT);
  localparam logic [15:0] DL = 16'(DLLK_CYCLES);
  localparam logic [15:0] ZQ = 16'(ZQINIT_CYCLES);
  localparam logic [15:0] AT = 16'(ACK_TIMEOUT);
  state_t      state_q, state_d;
  logic [4:0]  step_q, step_d;
  logic [15:0] cnt_q, cnt_d;
  logic [14:0] ent;
  logic        wr;
  // {register offset, data} for each table step
  function automatic logic [14:0] entry(input logic [4:0] s);
    case (s)
      5'd0:  entry = {ADR, 12'h000};
      5'd1:  entry = {BAD, 12'h000};
      5'd2:  entry = {CTL, 12'h00C};
      5'd3:  entry = {CTL, 12'h00E};
      5'd4:  entry = {ADR, 12'h200};
      5'd5:  entry = {BAD, 12'h002};
      5'd6:  entry = {CMD, 12'h00F};
      5'd7:  entry = {ISS, 12'h001};
      5'd8:  entry = {ADR, 12'h000};
      5'd9:  entry = {BAD, 12'h003};
      5'd10: entry = {CMD, 12'h00F};
      5'd11: entry = {ISS, 12'h001};
      5'd12: entry = {ADR, 12'h006};
      5'd13: entry = {BAD, 12'h001};
      5'd14: entry = {CMD, 12'h00F};
      5'd15: entry = {ISS, 12'h001};
      5'd16: entry = {ADR, 12'h320};
      5'd17: entry = {BAD, 12'h000};
      5'd18: entry = {CMD, 12'h00F};
      5'd19: entry = {ISS, 12'h001};
      5'd20: entry = {ADR, 12'h220};
      5'd21: entry = {BAD, 12'h000};
      5'd22: entry = {CMD, 12'h00F};
      5'd23: entry = {ISS, 12'h001};
      5'd24: entry = {ADR, 12'h400};
      5'd25: entry = {BAD, 12'h000};
      5'd26: entry = {CMD, 12'h003};
      5'd27: entry = {ISS, 12'h001};
      default: entry = {CTL, 12'h001};
    endcase
  endfunction
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, DONE: if (start) begin
        state_d = RST_WAIT;
        step_d  = '0;
        cnt_d   = RW;
      end
      RST_WAIT: if (cnt_q <= 16'd1) begin
        state_d = WRITE;
        cnt_d   = '0;
      end else cnt_d = cnt_q - 16'd1;
      DELAY: if (cnt_q <= 16'd1) begin
        state_d = WRITE;
        step_d  = step_q + 5'd1;
        cnt_d   = '0;
      end else cnt_d = cnt_q - 16'd1;
      WRITE: if (wb_ack) begin
        state_d = step_q == 5'd28 ? DONE : (step_q == 5'd23 || step_q == 5'd27) ? DELAY : GAP;
        cnt_d   = step_q == 5'd23 ? DL : step_q == 5'd27 ? ZQ : '0;
      end else if (cnt_q + 16'd1 >= AT) state_d = ERROR;
      else cnt_d = cnt_q + 16'd1;
      GAP: begin
        state_d = WRITE;
        step_d  = step_q + 5'd1;
      end
      ERROR: state_d = ERROR;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      step_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
    end
  end
  assign ent      = entry(step_q);
  assign wr       = state_q == WRITE;
  assign wb_cyc   = wr;
  assign wb_stb   = wr;
  assign wb_we    = wr;
  assign wb_sel   = wr ? 4'hF : 4'h0;
  assign wb_adr   = wr ? CSR_BASE + 30'(ent[14:12]) : '0;
  assign wb_dat_w = wr ? 32'(ent[11:0]) : '0;
  assign busy     = state_q == RST_WAIT || wr || state_q == GAP || state_q == DELAY;
  assign done     = state_q == DONE;
  assign error    = state_q == ERROR;
  assign step     = step_q;
endmodule

// File: tb/tb_dfii_init_sequencer.sv
// tb_dfii_init_sequencer: table-driven check of the DFII init write sequence, delays, timeout and reset.
module tb_dfii_init_sequencer;
  localparam int RESET_WAIT = 35, DLLK = 600, ZQINIT = 600, ACK_TO = 255;
  localparam logic [29:0] BASE = 30'h2400;
  logic clk = 0, rst = 1, start = 0, wb_ack = 0;
  logic busy, done, error, wb_cyc, wb_stb, wb_we;
  logic [4:0] step;
  logic [29:0] wb_adr;
  logic [31:0] wb_dat_w;
  logic [3:0] wb_sel;
  int checks = 0, errors = 0;
  typedef struct { int dly; logic [29:0] adr; logic [31:0] dat; } vec_t;
  vec_t v[29];
  dfii_init_sequencer #(.CSR_BASE(BASE), .RESET_WAIT(RESET_WAIT), .DLLK_CYCLES(DLLK),
    .ZQINIT_CYCLES(ZQINIT), .ACK_TIMEOUT(ACK_TO)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .error(error), .step(step),
    .wb_adr(wb_adr), .wb_dat_w(wb_dat_w), .wb_sel(wb_sel), .wb_cyc(wb_cyc), .wb_stb(wb_stb),
    .wb_we(wb_we), .wb_ack(wb_ack));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  task automatic finish_now();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask
  task automatic setv(input int i, input int dly, input int off, input int dat);
    v[i].dly = dly;
    v[i].adr = BASE + 30'(off);
    v[i].dat = 32'(dat);
  endtask
  task automatic pulse_start();
    start = 1;
    @(negedge clk);
    start = 0;
  endtask
  task automatic wait_stb(output int idle, input bit poke);
    idle = 0;
    while (!wb_stb && idle < 5000) begin
      idle++;
      start = poke && idle == 3;
      @(negedge clk);
    end
    start = 0;
    if (idle >= 5000) begin
      chk("stb_wait_timeout", 64'(idle), 64'(0));
      finish_now();
    end
  endtask
  task automatic run_seq(input int mode, input int stop_at, input bit poke);
    int idle, exp_idle, d;
    for (int i = 0; i < 29; i++) begin
      wait_stb(idle, poke);
      exp_idle = i == 0 ? RESET_WAIT : i == 24 ? DLLK : i == 28 ? ZQINIT : 1;
      chk($sformatf("idle_before_%0d", i), 64'(idle), 64'(exp_idle));
      chk($sformatf("adr_%0d", i), 64'(wb_adr), 64'(v[i].adr));
      chk($sformatf("dat_%0d", i), 64'(wb_dat_w), 64'(v[i].dat));
      chk($sformatf("step_%0d", i), 64'(step), 64'(i));
      chk($sformatf("ctl_%0d", i), 64'({wb_cyc, wb_we, wb_sel, busy}), 64'(7'b1111111));
      if (i == stop_at) return;
      d = mode == 0 ? v[i].dly : int'($urandom_range(10, 0));
      repeat (d) begin
        @(negedge clk);
        chk($sformatf("hold_%0d", i), {1'b0, wb_stb, wb_adr, wb_dat_w}, {1'b0, 1'b1, v[i].adr, v[i].dat});
      end
      wb_ack = 1;
      @(negedge clk);
      wb_ack = 0;
    end
    chk("final_status", 64'({done, busy, wb_cyc, error}), 64'(4'b1000));
  endtask
  initial begin
    int n;
    setv(0, 0, 3, 'h000); setv(1, 1, 4, 'h000); setv(2, 0, 0, 'h00C); setv(3, 2, 0, 'h00E);
    setv(4, 0, 3, 'h200); setv(5, 3, 4, 'h002); setv(6, 0, 1, 'h00F); setv(7, 1, 2, 'h001);
    setv(8, 0, 3, 'h000); setv(9, 0, 4, 'h003); setv(10, 4, 1, 'h00F); setv(11, 0, 2, 'h001);
    setv(12, 1, 3, 'h006); setv(13, 0, 4, 'h001); setv(14, 0, 1, 'h00F); setv(15, 2, 2, 'h001);
    setv(16, 0, 3, 'h320); setv(17, 0, 4, 'h000); setv(18, 1, 1, 'h00F); setv(19, 0, 2, 'h001);
    setv(20, 0, 3, 'h220); setv(21, 3, 4, 'h000); setv(22, 0, 1, 'h00F); setv(23, 0, 2, 'h001);
    setv(24, 2, 3, 'h400); setv(25, 0, 4, 'h000); setv(26, 0, 1, 'h003); setv(27, 1, 2, 'h001);
    setv(28, 0, 0, 'h001);
    repeat (3) @(negedge clk);
    chk("reset_outputs", {busy, done, error, step, wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_dat_w}, 64'd0);
    rst = 0;
    wb_ack = 1;
    repeat (2) @(negedge clk);
    wb_ack = 0;
    chk("idle_ignores_ack", 64'({busy, done, error, wb_cyc, step}), 64'd0);
    pulse_start();
    chk("busy_after_start", 64'({busy, done}), 64'(2'b10));
    run_seq(0, -1, 1);
    pulse_start();
    chk("rerun_from_done", 64'({busy, done}), 64'(2'b10));
    run_seq(1, -1, 0);
    pulse_start();
    run_seq(0, 12, 0);
    rst = 1;
    @(negedge clk);
    chk("mid_write_reset", {busy, done, error, step, wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_dat_w}, 64'd0);
    rst = 0;
    @(negedge clk);
    chk("no_resume", 64'({busy, wb_cyc, step}), 64'd0);
    pulse_start();
    run_seq(0, -1, 0);
    pulse_start();
    run_seq(0, 5, 0);
    n = 0;
    while (!error && n < 1000) begin
      @(negedge clk);
      n++;
      if (!error) chk("cyc_held_waiting", 64'(wb_cyc), 64'd1);
    end
    chk("timeout_cycles", 64'(n), 64'(ACK_TO));
    chk("error_state", 64'({error, done, busy, wb_cyc, wb_stb, step}), 64'({3'b100, 2'b00, 5'd5}));
    pulse_start();
    repeat (3) @(negedge clk);
    chk("error_ignores_start", 64'({error, busy, wb_cyc, step}), 64'({3'b100, 5'd5}));
    rst = 1;
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("error_cleared_by_rst", 64'({error, busy, step}), 64'd0);
    finish_now();
  end
endmodule
